// File: rtl/and_event_monitor_pkg.sv
// Shared types and defaults for the AND-output event monitor.
// No logic here; latency and backpressure do not apply.
package and_event_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_HELD = 2'd2
  } run_state_t;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_MIN_HIGH = 3;
  localparam int RUN_W        = 8;

endpackage

// File: rtl/and_event_monitor_if.sv
// Monitor-side signal bundle: qualified input, clear, snapshot handshake, and results.
// Latency: none. Backpressure: snap_valid is held until snap_ack is seen.
interface and_event_monitor_if #(
  parameter int CNT_W = 8
);

  logic             din;
  logic             clr;
  logic             snap_req;
  logic             snap_ack;
  logic             event_pulse;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic [CNT_W-1:0] snap_count;
  logic             snap_valid;

  modport master (
    output din, clr, snap_req, snap_ack,
    input  event_pulse, count, ovf, snap_count, snap_valid
  );

  modport slave (
    input  din, clr, snap_req, snap_ack,
    output event_pulse, count, ovf, snap_count, snap_valid
  );

endinterface

// File: rtl/and_event_monitor_high_run_qualifier.sv
// Flags the edge that takes the MIN_HIGH-th consecutive high sample of din.
// Latency: qualify is combinational on that edge. Backpressure: none.
module high_run_qualifier
  import and_event_monitor_pkg::*;
#(
  parameter int MIN_HIGH = DEF_MIN_HIGH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic qualify
);

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MIN_HIGH - 1);

  run_state_t       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             qual_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // A single-sample threshold qualifies straight out of IDLE.
  assign qual_now = din && (((state_q == S_IDLE) && (MIN_HIGH == 1)) ||
                            ((state_q == S_ARM) && (run_q == RUN_LAST)));

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    case (state_q)
      S_IDLE: begin
        if (din) begin
          if (qual_now) begin
            state_d = S_HELD;
            run_d   = '0;
          end else begin
            state_d = S_ARM;
            run_d   = RUN_W'(1);
          end
        end
      end
      S_ARM: begin
        if (!din) begin
          state_d = S_IDLE;
          run_d   = '0;
        end else if (qual_now) begin
          state_d = S_HELD;
          run_d   = '0;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end
      S_HELD: begin
        if (!din) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        run_d   = '0;
      end
    endcase
  end

  always_comb begin
    qualify = qual_now;
  end

endmodule

// File: rtl/and_event_monitor.sv
// Counts qualified high runs of din with a saturating counter, sticky ovf and snapshot port.
// Latency: event_pulse and count update one cycle after qualify. Backpressure: snapshot held until acked.
module and_event_monitor
  import and_event_monitor_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MIN_HIGH = DEF_MIN_HIGH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  and_event_monitor_if.slave   mon
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             qual;
  logic             pulse_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic [CNT_W-1:0] snap_q;
  logic             snap_vld_q;

  high_run_qualifier #(
    .MIN_HIGH (MIN_HIGH)
  ) u_qual (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (mon.din),
    .qualify (qual)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pulse_q <= qual;
      // Clear takes priority over a coincident qualify; the pulse still fires.
      if (mon.clr) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (qual) begin
        if (count_q == CNT_MAX) ovf_q <= 1'b1;
        else                    count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Snapshot captures the pre-edge count, so clr or an increment on the same edge is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q     <= '0;
      snap_vld_q <= 1'b0;
    end else if (snap_vld_q) begin
      if (mon.snap_ack) snap_vld_q <= 1'b0;
    end else if (mon.snap_req) begin
      snap_q     <= count_q;
      snap_vld_q <= 1'b1;
    end
  end

  assign mon.event_pulse = pulse_q;
  assign mon.count       = count_q;
  assign mon.ovf         = ovf_q;
  assign mon.snap_count  = snap_q;
  assign mon.snap_valid  = snap_vld_q;

endmodule

// File: tb/tb_and_event_monitor.sv
// Drives 8-bit and 2-bit counter instances with identical stimulus and checks both
// against a run-length / saturating-arithmetic reference model.
module tb_and_event_monitor;

  localparam int MINH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0, clr = 1'b0, snap_req = 1'b0, snap_ack = 1'b0;

  always #5 clk = ~clk;

  and_event_monitor_if #(.CNT_W(8)) m8 ();
  and_event_monitor_if #(.CNT_W(2)) m2 ();

  assign m8.din = din;  assign m8.clr = clr;  assign m8.snap_req = snap_req;  assign m8.snap_ack = snap_ack;
  assign m2.din = din;  assign m2.clr = clr;  assign m2.snap_req = snap_req;  assign m2.snap_ack = snap_ack;

  and_event_monitor #(.CNT_W(8), .MIN_HIGH(MINH)) dut8 (.clk(clk), .rst_n(rst_n), .mon(m8));
  and_event_monitor #(.CNT_W(2), .MIN_HIGH(MINH)) dut2 (.clk(clk), .rst_n(rst_n), .mon(m2));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: length of the current high run, and per-width results.
  int run_len;
  bit exp_pulse;
  int c8, c2, s8, s2;
  bit o8, o2, v8, v2;

  logic [18:0] e8, a8;
  logic [6:0]  e2, a2;

  assign a8 = {m8.event_pulse, m8.count, m8.ovf, m8.snap_count, m8.snap_valid};
  assign a2 = {m2.event_pulse, m2.count, m2.ovf, m2.snap_count, m2.snap_valid};

  task automatic pack_exp();
    e8 = {exp_pulse, 8'(c8), o8, 8'(s8), v8};
    e2 = {exp_pulse, 2'(c2), o2, 2'(s2), v2};
  endtask

  task automatic model_reset();
    run_len = 0; exp_pulse = 0;
    c8 = 0; c2 = 0; s8 = 0; s2 = 0;
    o8 = 0; o2 = 0; v8 = 0; v2 = 0;
    pack_exp();
  endtask

  task automatic step(input bit d, input bit c, input bit rq, input bit ak);
    bit q;
    din = d; clr = c; snap_req = rq; snap_ack = ak;
    @(posedge clk);
    q = d && (run_len + 1 == MINH);
    run_len = d ? run_len + 1 : 0;
    exp_pulse = q;
    if (v8) begin if (ak) v8 = 0; end
    else if (rq) begin s8 = c8; v8 = 1; end
    if (v2) begin if (ak) v2 = 0; end
    else if (rq) begin s2 = c2; v2 = 1; end
    if (c) begin
      c8 = 0; o8 = 0; c2 = 0; o2 = 0;
    end else if (q) begin
      if (c8 == 255) o8 = 1; else c8++;
      if (c2 == 3)   o2 = 1; else c2++;
    end
    pack_exp();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks += 2;
      if (a8 !== e8) begin n_fail++; $display("FAIL reset_hold w8 got=%h exp=%h", a8, e8); end
      if (a2 !== e2) begin n_fail++; $display("FAIL reset_hold w2 got=%h exp=%h", a2, e2); end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      n_checks += 2;
      if (a8 !== e8) begin n_fail++; $display("FAIL reset_idle w8 cyc=%0d got=%h exp=%h", i, a8, e8); end
      if (a2 !== e2) begin n_fail++; $display("FAIL reset_idle w2 cyc=%0d got=%h exp=%h", i, a2, e2); end
    end
  endtask

  task automatic test_qualify();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 7; i++) begin
        step(i < 5, 0, 0, 0);
        n_checks += 2;
        if (a8 !== e8) begin n_fail++; $display("FAIL qualify w8 run=%0d cyc=%0d got=%h exp=%h", r, i, a8, e8); end
        if (m8.event_pulse !== (i == 2)) begin
          n_fail++; $display("FAIL qualify_latency run=%0d cyc=%0d pulse=%b", r, i, m8.event_pulse);
        end
      end
    end
    n_checks++;
    if (m8.count !== 8'd4) begin n_fail++; $display("FAIL qualify_count got=%0d exp=4", m8.count); end
  endtask

  task automatic test_glitch();
    bit pat [8] = '{1, 0, 1, 1, 0, 1, 1, 0};
    step(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(pat[i], 0, 0, 0);
      n_checks += 2;
      if (a8 !== e8) begin n_fail++; $display("FAIL glitch w8 cyc=%0d got=%h exp=%h", i, a8, e8); end
      if (m8.event_pulse !== 1'b0) begin n_fail++; $display("FAIL glitch_pulse cyc=%0d got=1 exp=0", i); end
    end
    n_checks++;
    if (m8.count !== 8'd0) begin n_fail++; $display("FAIL glitch_count got=%0d exp=0", m8.count); end
  endtask

  task automatic test_saturation();
    step(0, 1, 0, 0);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 5; i++) begin
        step(i < 4, 0, 0, 0);
        n_checks += 2;
        if (a2 !== e2) begin n_fail++; $display("FAIL sat w2 run=%0d cyc=%0d got=%h exp=%h", r, i, a2, e2); end
        if (a8 !== e8) begin n_fail++; $display("FAIL sat w8 run=%0d cyc=%0d got=%h exp=%h", r, i, a8, e8); end
      end
      if (r == 3) begin
        n_checks++;
        if ({m2.count, m2.ovf} !== 3'b111) begin
          n_fail++; $display("FAIL sat_after4 count=%0d ovf=%b exp count=3 ovf=1", m2.count, m2.ovf);
        end
      end
    end
    step(0, 1, 0, 0);
    n_checks += 2;
    if ({m2.count, m2.ovf} !== 3'b000) begin
      n_fail++; $display("FAIL sat_clr count=%0d ovf=%b exp count=0 ovf=0", m2.count, m2.ovf);
    end
    if (a8 !== e8) begin n_fail++; $display("FAIL sat_clr w8 got=%h exp=%h", a8, e8); end
  endtask

  task automatic test_snapshot();
    step(0, 1, 0, 0);
    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < 5; i++) begin
        step(i < 3, 0, 0, 0);
        n_checks += 2;
        if (a8 !== e8) begin n_fail++; $display("FAIL snap_runs w8 run=%0d got=%h exp=%h", r, a8, e8); end
        if (a2 !== e2) begin n_fail++; $display("FAIL snap_runs w2 run=%0d got=%h exp=%h", r, a2, e2); end
      end
      if (r == 4) begin
        step(0, 0, 1, 0);
        n_checks++;
        if ({m8.snap_valid, m8.snap_count} !== {1'b1, 8'd5}) begin
          n_fail++; $display("FAIL snap_first valid=%b snap=%0d exp valid=1 snap=5", m8.snap_valid, m8.snap_count);
        end
      end
    end
    n_checks++;
    if ({m8.count, m8.snap_count} !== {8'd7, 8'd5}) begin
      n_fail++; $display("FAIL snap_hold count=%0d snap=%0d exp count=7 snap=5", m8.count, m8.snap_count);
    end
    step(0, 0, 1, 0);
    n_checks++;
    if (a8 !== e8) begin n_fail++; $display("FAIL snap_ignored w8 got=%h exp=%h", a8, e8); end
    step(0, 0, 0, 1);
    n_checks++;
    if ({m8.snap_valid, m8.snap_count} !== {1'b0, 8'd5}) begin
      n_fail++; $display("FAIL snap_ack valid=%b snap=%0d exp valid=0 snap=5", m8.snap_valid, m8.snap_count);
    end
    step(0, 0, 1, 0);
    n_checks += 2;
    if ({m8.snap_valid, m8.snap_count} !== {1'b1, 8'd7}) begin
      n_fail++; $display("FAIL snap_second valid=%b snap=%0d exp valid=1 snap=7", m8.snap_valid, m8.snap_count);
    end
    if (a2 !== e2) begin n_fail++; $display("FAIL snap_second w2 got=%h exp=%h", a2, e2); end
  endtask

  task automatic test_collision();
    step(0, 0, 1, 1);
    step(0, 1, 0, 0);
    for (int r = 0; r < 6; r++)
      for (int i = 0; i < 4; i++) step(i < 3, 0, 0, 0);
    n_checks++;
    if (a8 !== e8) begin n_fail++; $display("FAIL collide_pre w8 got=%h exp=%h", a8, e8); end
    step(0, 1, 1, 0);
    n_checks += 2;
    if ({m8.snap_count, m8.count, m8.snap_valid} !== {8'd6, 8'd0, 1'b1}) begin
      n_fail++; $display("FAIL collide_req_clr snap=%0d count=%0d exp snap=6 count=0", m8.snap_count, m8.count);
    end
    if (a2 !== e2) begin n_fail++; $display("FAIL collide_req_clr w2 got=%h exp=%h", a2, e2); end
    step(0, 0, 0, 1);
    // Qualify and snapshot request on the same edge: snapshot sees the old count.
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 1, 0);
    n_checks++;
    if ({m8.snap_count, m8.count, m8.event_pulse} !== {8'd0, 8'd1, 1'b1}) begin
      n_fail++; $display("FAIL collide_req_qual snap=%0d count=%0d pulse=%b exp snap=0 count=1 pulse=1",
                         m8.snap_count, m8.count, m8.event_pulse);
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 6) == 0, ($urandom % 5) == 0);
      n_checks += 2;
      if (a8 !== e8) begin n_fail++; $display("FAIL random w8 cyc=%0d got=%h exp=%h", i, a8, e8); end
      if (a2 !== e2) begin n_fail++; $display("FAIL random w2 cyc=%0d got=%h exp=%h", i, a2, e2); end
    end
  endtask

  task automatic test_async_reset();
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(i < 3, 0, 0, 0);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks += 2;
    if (a8 !== e8) begin n_fail++; $display("FAIL async_reset w8 got=%h exp=%h", a8, e8); end
    if (a2 !== e2) begin n_fail++; $display("FAIL async_reset w2 got=%h exp=%h", a2, e2); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(i < 2, 0, 0, 0);
      n_checks += 2;
      if (a8 !== e8) begin n_fail++; $display("FAIL post_reset w8 cyc=%0d got=%h exp=%h", i, a8, e8); end
      if (m8.event_pulse !== 1'b0) begin n_fail++; $display("FAIL post_reset_pulse cyc=%0d got=1 exp=0", i); end
    end
  endtask

  initial begin
    test_reset();
    test_qualify();
    test_glitch();
    test_saturation();
    test_snapshot();
    test_collision();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
